mem_backend: RTL

MEM_BACKEND -- requirements
Module: mem_backend

---
 rtl/mem_backend.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_backend.sv
// mem_backend: fixed-latency word-addressed backing store behind the cache.
// A request is accepted in IDLE, timed in BUSY and completed in DONE; the
// completion pulse ready_o and the read data appear together on the cycle
// after DONE, so a held request is re-accepted in that same cycle.
// Optional feature: define MEM_BACKEND_WBUF_EN to add a one-entry posted
// write buffer that acknowledges writes early and drains them later.
module mem_backend #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam int         AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_accept, w_complete;
  logic        w_can_accept, w_direct_done, w_stall;
  logic        r_op_wr;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_unused_addr;

  // Word index: byte offset and bits above the array size are dropped, so
  // out-of-range addresses alias back into the array.
  assign w_idx         = addr_i[AW+1:2];
  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef MEM_BACKEND_WBUF_EN
  logic          r_wb_vld;
  logic [AW-1:0] r_wb_idx;
  logic [31:0]   r_wb_data;
  logic [3:0]    r_wb_cnt;
  logic          w_wb_cap, w_wb_drain;

  // Writes need a free buffer slot; rd+wr together counts as a write.
  assign w_can_accept  = wr_i ? !r_wb_vld : rd_i;
  // Buffered writes acknowledge at once; a read skips BUSY only when LATENCY
  // is 1 and it will not have to wait for an unrelated drain.
  assign w_direct_done = wr_i | ((LOAD == 4'd0) & !(r_wb_vld & (w_idx != r_wb_idx)));
  // A read to another word holds its count until the pending drain is done.
  assign w_stall       = r_wb_vld & !r_op_wr & (r_idx != r_wb_idx);
  // Forward buffered data to a read of the same word.
  assign w_rd_word     = (r_wb_vld && (r_wb_idx == r_idx)) ? r_wb_data : r_mem[r_idx];
  assign w_wb_cap      = w_accept & wr_i;
  assign w_wb_drain    = r_wb_vld & (r_wb_cnt == 4'd0);
  assign busy_o        = (r_state != IDLE) | r_wb_vld;
`else
  logic [31:0] r_wdata;

  assign w_can_accept  = rd_i | wr_i;
  assign w_direct_done = (LOAD == 4'd0);
  assign w_stall       = 1'b0;
  assign w_rd_word     = r_mem[r_idx];
  assign busy_o        = (r_state != IDLE);
`endif

  // Next-state and counter logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_accept) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LOAD;
          w_state_nxt = w_direct_done ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!w_stall) begin
          if (r_cnt <= 4'd1) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      DONE: begin
        w_complete  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the operation and its word index when a request is accepted.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op_wr <= wr_i;
      r_idx   <= w_idx;
`ifndef MEM_BACKEND_WBUF_EN
      r_wdata <= wdata_i;
`endif
    end
  end

  // Completion pulse and read data register; writes leave rdata_o alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o <= 1'b0;
      rdata_o <= 32'h0;
    end else begin
      ready_o <= w_complete;
      if (w_complete && !r_op_wr) rdata_o <= w_rd_word;
    end
  end

`ifdef MEM_BACKEND_WBUF_EN
  // Write buffer valid bit and drain timer; reset discards a pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_vld <= 1'b0;
      r_wb_cnt <= 4'd0;
    end else if (w_wb_cap) begin
      r_wb_vld <= 1'b1;
      r_wb_cnt <= LOAD;
    end else if (w_wb_drain) begin
      r_wb_vld <= 1'b0;
    end else if (r_wb_vld) begin
      r_wb_cnt <= r_wb_cnt - 4'd1;
    end
  end

  // Write buffer payload.
  always_ff @(posedge clk_i) begin
    if (w_wb_cap) begin
      r_wb_idx  <= w_idx;
      r_wb_data <= wdata_i;
    end
  end

  // Backing store: written only when the buffer drains; never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wb_drain) r_mem[r_wb_idx] <= r_wb_data;
  end
`else
  // Backing store: written when a write completes; never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_complete && r_op_wr) r_mem[r_idx] <= r_wdata;
  end
`endif

endmodule
